// File: rtl/inst_mem_ctrl.sv
// Writable instruction memory for the fetch stage: self-clears after reset,
// accepts loader writes and serves fetches with one-cycle latency and fault reporting.
//
// state | meaning
// INIT  | clearing word[cnt] to DEFAULT_INST, one word per cycle; fetch/load ignored
// RUN   | serving fetches and loader writes until the next reset
module inst_mem_ctrl #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                DEPTH        = 256,
  parameter int                BYTE_ADDR    = 1,
  parameter logic [DATA_W-1:0] DEFAULT_INST = '0,
  localparam int               IDX_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_err,
  output logic [1:0]        err_code,
  input  logic              load_en,
  input  logic [IDX_W:0]    load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  idx;
  logic               misaligned;
  logic               out_of_range;
  logic               accept;
  logic               load_ok;

  always_comb begin
    idx          = (BYTE_ADDR != 0) ? (pc_addr >> 2) : pc_addr;
    misaligned   = (BYTE_ADDR != 0) && (pc_addr[1:0] != 2'b00);
    out_of_range = (idx >> IDX_W) != '0;
  end

  assign fetch_ready = (state == RUN) && !load_en && !(inst_valid && fetch_stall);
  assign accept      = fetch_req && fetch_ready;
  assign load_ok     = (state == RUN) && load_en && !load_addr[IDX_W];

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[cnt] <= DEFAULT_INST;
    end else if (load_ok) begin
      mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= '0;
      init_done  <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= DEFAULT_INST;
      inst_pc    <= '0;
      fetch_err  <= 1'b0;
      err_code   <= 2'b00;
      load_err   <= 1'b0;
    end else begin
      load_err <= (state == RUN) && load_en && load_addr[IDX_W];
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            inst_valid <= 1'b1;
            inst_pc    <= pc_addr;
            // Misalignment outranks range; a faulted fetch never reads the array.
            if (misaligned) begin
              fetch_err <= 1'b1;
              err_code  <= 2'b01;
              inst_data <= DEFAULT_INST;
            end else if (out_of_range) begin
              fetch_err <= 1'b1;
              err_code  <= 2'b10;
              inst_data <= DEFAULT_INST;
            end else begin
              fetch_err <= 1'b0;
              err_code  <= 2'b00;
              inst_data <= mem[idx[IDX_W-1:0]];
            end
          end else if (!(inst_valid && fetch_stall)) begin
            inst_valid <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
